// File: rtl/tof_sched_pkg.sv
// Shared types and constants for the TOF config-update scheduler.
// State encoding, flag bit position, default geometry, stats-clear address.
package tof_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CHK,
    S_OFFER,
    S_CLR
  } scan_state_e;

  localparam int          NEEDS_UPDATE_BIT = 15;
  localparam int          CFG_WORDS_DEF    = 128;
  localparam logic [9:0]  MON_BASE_DEF     = 10'h080;
  localparam logic [9:0]  STATS_CLR_ADDR   = 10'h3FF;

endpackage

// File: rtl/tof_cfg_update_scheduler_if.sv
// Update-offer handshake between the scheduler and the TOF controller.
// master drives the offer, slave accepts it with ready.
interface tof_cfg_update_scheduler_if;
  import tof_sched_pkg::*;

  logic        valid;
  logic [6:0]  addr;
  logic [14:0] dat;
  logic        ready;

  modport master (
    output valid,
    output addr,
    output dat,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  dat,
    output ready
  );

endinterface

// File: rtl/tof_bram_port_arb.sv
// Fixed-priority grant (monitor > host > scanner) and BRAM port mux.
// Purely combinational; the port always stays enabled.
module tof_bram_port_arb
  import tof_sched_pkg::*;
#(
  parameter logic [9:0] MON_BASE = MON_BASE_DEF
) (
  input  logic        mon_wr_i,
  input  logic [6:0]  mon_addr_i,
  input  logic [15:0] mon_dat_i,
  input  logic        host_req_i,
  input  logic        host_wr_i,
  input  logic [9:0]  host_addr_i,
  input  logic [15:0] host_dat_i,
  input  logic        scan_req_i,
  input  logic        scan_wr_i,
  input  logic [9:0]  scan_addr_i,
  input  logic [15:0] scan_dat_i,
  output logic        mon_gnt_o,
  output logic        host_gnt_o,
  output logic        scan_gnt_o,
  output logic [9:0]  bram_addr_o,
  output logic [15:0] bram_dat_o,
  output logic        bram_wr_o,
  output logic        bram_en_o
);

  assign mon_gnt_o  = mon_wr_i;
  assign host_gnt_o = host_req_i & ~mon_wr_i;
  assign scan_gnt_o = scan_req_i & ~mon_wr_i & ~host_req_i;
  assign bram_en_o  = 1'b1;

  always_comb begin
    bram_addr_o = '0;
    bram_dat_o  = '0;
    bram_wr_o   = 1'b0;
    unique case (1'b1)
      mon_gnt_o: begin
        bram_addr_o = MON_BASE + {3'b000, mon_addr_i};
        bram_dat_o  = mon_dat_i;
        bram_wr_o   = 1'b1;
      end
      host_gnt_o: begin
        bram_addr_o = host_addr_i;
        bram_dat_o  = host_dat_i;
        bram_wr_o   = host_wr_i;
      end
      scan_gnt_o: begin
        bram_addr_o = scan_addr_i;
        bram_dat_o  = scan_dat_i;
        bram_wr_o   = scan_wr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tof_cfg_update_scheduler.sv
// Scans config BRAM for needs-update words, offers them, clears the flag.
// Optional TOF_SCHED_STATS_EN adds a saturating completed-clear counter.
module tof_cfg_update_scheduler
  import tof_sched_pkg::*;
#(
  parameter int         CFG_WORDS = CFG_WORDS_DEF,
  parameter logic [9:0] MON_BASE  = MON_BASE_DEF
) (
  input  logic        clk200_i,
  input  logic        rst_n_i,
  input  logic        scan_en_i,
  output logic        scan_busy_o,
  input  logic        mon_wr_i,
  input  logic [6:0]  mon_addr_i,
  input  logic [15:0] mon_dat_i,
  input  logic        host_rd_i,
  input  logic        host_wr_i,
  input  logic [9:0]  host_addr_i,
  input  logic [15:0] host_dat_i,
  output logic        host_ack_o,
  output logic [15:0] host_dat_o,
  tof_cfg_update_scheduler_if.master upd,
  output logic [9:0]  bram_addr_o,
  output logic [15:0] bram_dat_o,
  output logic        bram_wr_o,
  output logic        bram_en_o,
  input  logic [15:0] bram_dat_i
`ifdef TOF_SCHED_STATS_EN
  ,
  output logic [15:0] upd_count_o
`endif
);

  localparam logic [6:0] PTR_MASK = 7'(CFG_WORDS - 1);

  scan_state_e state_q, state_d;
  logic [6:0]  ptr_q, ptr_d;
  logic        dirty_q, dirty_d;
  logic [14:0] lat_q, lat_d;
  logic        host_ack_q, host_ack_d;
  logic        host_rd_q, host_rd_d;

  logic        host_req, host_gnt, mon_gnt, scan_gnt;
  logic        host_fwd_wr, host_hit;
  logic        scan_req, scan_wr;
  logic [6:0]  ptr_nxt;

  assign host_req = (host_rd_i | host_wr_i) & ~host_ack_q;

`ifdef TOF_SCHED_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  logic        stat_clr;
  assign host_fwd_wr = host_wr_i & (host_addr_i != STATS_CLR_ADDR);
  assign stat_clr    = host_gnt & host_wr_i
                     & (host_addr_i == STATS_CLR_ADDR);
  assign upd_count_o = cnt_q;
`else
  assign host_fwd_wr = host_wr_i;
`endif

  assign ptr_nxt  = (ptr_q + 7'd1) & PTR_MASK;
  assign host_hit = host_gnt & host_wr_i
                  & (host_addr_i == {3'b000, ptr_q});
  assign scan_req = (state_q == S_RD)
                  | ((state_q == S_CLR) & ~dirty_q);
  assign scan_wr  = (state_q == S_CLR);

  tof_bram_port_arb #(
    .MON_BASE (MON_BASE)
  ) u_arb (
    .mon_wr_i    (mon_wr_i),
    .mon_addr_i  (mon_addr_i),
    .mon_dat_i   (mon_dat_i),
    .host_req_i  (host_req),
    .host_wr_i   (host_fwd_wr),
    .host_addr_i (host_addr_i),
    .host_dat_i  (host_dat_i),
    .scan_req_i  (scan_req),
    .scan_wr_i   (scan_wr),
    .scan_addr_i ({3'b000, ptr_q}),
    .scan_dat_i  ({1'b0, lat_q}),
    .mon_gnt_o   (mon_gnt),
    .host_gnt_o  (host_gnt),
    .scan_gnt_o  (scan_gnt),
    .bram_addr_o (bram_addr_o),
    .bram_dat_o  (bram_dat_o),
    .bram_wr_o   (bram_wr_o),
    .bram_en_o   (bram_en_o)
  );

  always_comb begin
    host_ack_d = host_gnt;
    host_rd_d  = host_gnt & ~host_wr_i;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dirty_d = dirty_q;
    lat_d   = lat_q;
    if (host_hit && (state_q inside {S_CHK, S_OFFER, S_CLR}))
      dirty_d = 1'b1;
    unique case (state_q)
      S_IDLE: if (scan_en_i) state_d = S_RD;
      S_RD:   if (scan_gnt) state_d = S_CHK;
      S_CHK: begin
        if (dirty_q || host_hit) begin
          state_d = S_RD;
        end else if (bram_dat_i[NEEDS_UPDATE_BIT]) begin
          lat_d   = bram_dat_i[14:0];
          state_d = S_OFFER;
        end else begin
          ptr_d   = ptr_nxt;
          state_d = scan_en_i ? S_RD : S_IDLE;
        end
      end
      S_OFFER: if (upd.ready) state_d = S_CLR;
      S_CLR: begin
        // a host rewrite during the offer keeps the new flag alive
        if (dirty_q) begin
          state_d = S_RD;
        end else if (scan_gnt) begin
          ptr_d   = ptr_nxt;
          state_d = scan_en_i ? S_RD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RD && state_q != S_RD)
      dirty_d = 1'b0;
  end

`ifdef TOF_SCHED_STATS_EN
  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr)
      cnt_d = '0;
    else if (scan_wr && !dirty_q && scan_gnt && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk200_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk200_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      dirty_q    <= 1'b0;
      lat_q      <= '0;
      host_ack_q <= 1'b0;
      host_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      dirty_q    <= dirty_d;
      lat_q      <= lat_d;
      host_ack_q <= host_ack_d;
      host_rd_q  <= host_rd_d;
    end
  end

  assign scan_busy_o = (state_q != S_IDLE);
  assign host_ack_o  = host_ack_q;
  assign host_dat_o  = host_rd_q ? bram_dat_i : 16'h0000;
  assign upd.valid   = (state_q == S_OFFER);
  assign upd.addr    = ptr_q;
  assign upd.dat     = lat_q;

endmodule

// File: tb/tb_tof_cfg_update_scheduler.sv
// Directed and randomized bench for tof_cfg_update_scheduler.
// Holds a BRAM model plus an offer/write log and expected-value model.
module tb_tof_cfg_update_scheduler;
  import tof_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en, scan_busy;
  logic        mon_wr;
  logic [6:0]  mon_addr;
  logic [15:0] mon_dat;
  logic        host_rd, host_wr, host_ack;
  logic [9:0]  host_addr;
  logic [15:0] host_wdat, host_rdat;
  logic [9:0]  bram_addr;
  logic [15:0] bram_wdat;
  logic        bram_wr, bram_en;
  logic [15:0] rd_q;
`ifdef TOF_SCHED_STATS_EN
  logic [15:0] upd_count;
`endif

  logic [15:0] mem [0:1023];
  logic        pl_clr = 1'b0;
  logic        pl_we = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [15:0] pl_dat = '0;

  logic [6:0]  off_addr [$];
  logic [14:0] off_dat  [$];
  logic [9:0]  cw_addr  [$];
  logic [15:0] cw_dat   [$];

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tof_cfg_update_scheduler_if upd_if ();

  tof_cfg_update_scheduler dut (
    .clk200_i    (clk),
    .rst_n_i     (rst_n),
    .scan_en_i   (scan_en),
    .scan_busy_o (scan_busy),
    .mon_wr_i    (mon_wr),
    .mon_addr_i  (mon_addr),
    .mon_dat_i   (mon_dat),
    .host_rd_i   (host_rd),
    .host_wr_i   (host_wr),
    .host_addr_i (host_addr),
    .host_dat_i  (host_wdat),
    .host_ack_o  (host_ack),
    .host_dat_o  (host_rdat),
    .upd         (upd_if),
    .bram_addr_o (bram_addr),
    .bram_dat_o  (bram_wdat),
    .bram_wr_o   (bram_wr),
    .bram_en_o   (bram_en),
    .bram_dat_i  (rd_q)
`ifdef TOF_SCHED_STATS_EN
    ,
    .upd_count_o (upd_count)
`endif
  );

  // single-port BRAM, read-first, one-cycle latency
  always @(posedge clk) begin
    if (pl_clr)
      for (int k = 0; k < 1024; k++) mem[k] <= 16'h0000;
    else if (pl_we)
      mem[pl_addr] <= pl_dat;
    else if (bram_en && bram_wr)
      mem[bram_addr] <= bram_wdat;
    if (bram_en) rd_q <= mem[bram_addr];
  end

  always @(posedge clk) begin
    if (upd_if.valid && upd_if.ready) begin
      off_addr.push_back(upd_if.addr);
      off_dat.push_back(upd_if.dat);
    end
    if (bram_en && bram_wr && bram_addr < 10'h080) begin
      cw_addr.push_back(bram_addr);
      cw_dat.push_back(bram_wdat);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [15:0] d);
    pl_we = 1'b1; pl_addr = a; pl_dat = d;
    step();
    pl_we = 1'b0;
  endtask

  task automatic clr_mem();
    pl_clr = 1'b1;
    step();
    pl_clr = 1'b0;
  endtask

  task automatic do_reset();
    scan_en = 0; mon_wr = 0; host_rd = 0; host_wr = 0;
    upd_if.ready = 0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (upd_if.valid || n >= max) break;
      step();
      n++;
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!scan_busy) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic wait_offers(input int target, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (off_addr.size() >= target) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic host_op(input bit wr, input logic [9:0] a,
                         input logic [15:0] d,
                         output logic [15:0] rdat, output bit ok);
    host_wr = wr; host_rd = !wr; host_addr = a; host_wdat = d;
    ok = 0; rdat = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_ack) begin ok = 1; rdat = host_rdat; break; end
      step();
    end
    step();
    host_wr = 0; host_rd = 0;
  endtask

  initial begin
    int n, s, w, nexp, bad;
    bit ok, stable;
    logic ack5, ack6;
    logic [15:0] hv, hd, rd;
    logic [14:0] pay, pa, pb;
    logic [6:0]  ma [10];
    logic [15:0] md [10];
    logic [15:0] cfg_exp [128];
    logic [15:0] mon_exp [128];
    logic [6:0]  exp_a [$];
    logic [14:0] exp_d [$];

    scan_en = 0; mon_wr = 0; mon_addr = '0; mon_dat = '0;
    host_rd = 0; host_wr = 0; host_addr = '0; host_wdat = '0;
    upd_if.ready = 0;
    clr_mem();

    @(negedge clk);
    chk("rst busy", scan_busy, 0);
    chk("rst valid", upd_if.valid, 0);
    chk("rst addr", upd_if.addr, 0);
    chk("rst dat", upd_if.dat, 0);
    chk("rst ack", host_ack, 0);
    chk("rst hdat", host_rdat, 0);
    chk("rst bwr", bram_wr, 0);
    chk("rst ben", bram_en, 1);
    chk("rst baddr", bram_addr, 0);
`ifdef TOF_SCHED_STATS_EN
    chk("rst count", upd_count, 0);
`endif
    step();

    // single flagged word, ready tied high
    poke(10'd5, 16'h8123);
    s = off_addr.size();
    upd_if.ready = 1; rst_n = 1; scan_en = 1;
    repeat (300) step();
    scan_en = 0;
    wait_idle(20, ok);
    chk("t1 idle", ok, 1);
    chk("t1 offers", off_addr.size() - s, 1);
    chk("t1 addr", off_addr[s], 5);
    chk("t1 dat", off_dat[s], 15'h0123);
    chk("t1 mem5", mem[5], 16'h0123);
    step();

    // monitor writes starve a pending host read
    do_reset();
    hv = 16'($urandom);
    poke(10'h200, hv);
    n = $urandom_range(0, 100);
    for (int i = 0; i < 10; i++) begin
      ma[i] = 7'(n + i);
      md[i] = 16'($urandom);
      mon_wr = 1; mon_addr = ma[i]; mon_dat = md[i];
      host_rd = 1; host_addr = 10'h200;
      @(negedge clk);
      if (i == 0) begin
        chk("t2 baddr", bram_addr, 10'h080 + 10'(ma[0]));
        chk("t2 bwr", bram_wr, 1);
      end
      if (host_ack) chk("t2 early ack", host_ack, 0);
      step();
    end
    mon_wr = 0;
    @(negedge clk);
    chk("t2 ack grant cyc", host_ack, 0);
    step();
    @(negedge clk);
    chk("t2 ack", host_ack, 1);
    chk("t2 rdat", host_rdat, hv);
    step();
    host_rd = 0;
    for (int i = 0; i < 10; i++)
      chk($sformatf("t2 mon %0d", i), mem[10'h080 + 10'(ma[i])], md[i]);

    // offer stall, host write during stall, then rewrite race
    do_reset();
    clr_mem();
    poke(10'd3, 16'h8001);
    s = off_addr.size();
    w = cw_addr.size();
    scan_en = 1;
    wait_valid(50, n);
    chk("t3 offer latency", n, 9);
    chk("t3 addr", upd_if.addr, 3);
    chk("t3 dat", upd_if.dat, 15'h0001);
    step();
    stable = 1; ack5 = 0; ack6 = 0;
    hd = 16'($urandom);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin host_wr = 1; host_addr = 10'h300; host_wdat = hd; end
      if (i == 6) host_wr = 0;
      @(negedge clk);
      if (!(upd_if.valid === 1'b1 && upd_if.addr === 7'd3
            && upd_if.dat === 15'h0001)) stable = 0;
      if (i == 5) ack5 = host_ack;
      if (i == 6) ack6 = host_ack;
      step();
    end
    chk("t3 stable", stable, 1);
    chk("t3 ack grant", ack5, 0);
    chk("t3 ack", ack6, 1);
    chk("t3 host mem", mem[10'h300], hd);
    chk("t3 no xfer", off_addr.size() - s, 0);
    host_op(1, 10'd3, 16'h8002, rd, ok);
    chk("t4 host ack", ok, 1);
    upd_if.ready = 1;
    wait_offers(s + 2, 100, ok);
    chk("t4 two offers", ok, 1);
    step();
    scan_en = 0;
    wait_idle(20, ok);
    chk("t4 idle", ok, 1);
    chk("t4 noff", off_addr.size() - s, 2);
    chk("t4 off1", {off_addr[s], off_dat[s]}, {7'd3, 15'h0001});
    chk("t4 off2", {off_addr[s+1], off_dat[s+1]}, {7'd3, 15'h0002});
    chk("t4 ncw", cw_addr.size() - w, 2);
    chk("t4 cw1", {cw_addr[w], cw_dat[w]}, {10'd3, 16'h8002});
    chk("t4 cw2", {cw_addr[w+1], cw_dat[w+1]}, {10'd3, 16'h0002});
    chk("t4 mem3", mem[3], 16'h0002);

    // drop enable mid-offer
    step();
    do_reset();
    clr_mem();
    pay = 15'($urandom);
    poke(10'd10, {1'b1, pay});
    s = off_addr.size();
    scan_en = 1;
    wait_valid(50, n);
    chk("t5 addr", upd_if.addr, 10);
    step();
    scan_en = 0;
    repeat (3) step();
    upd_if.ready = 1;
    step();
    upd_if.ready = 0;
    wait_idle(20, ok);
    chk("t5 idle", ok, 1);
    chk("t5 busy", scan_busy, 0);
    chk("t5 off", {off_addr[s], off_dat[s]}, {7'd10, pay});
    chk("t5 mem", mem[10], {1'b0, pay});
    step();
    poke(10'd10, 16'h8055);
    poke(10'd12, 16'h8066);
    s = off_addr.size();
    scan_en = 1; upd_if.ready = 1;
    wait_offers(s + 2, 400, ok);
    chk("t5 resume offers", ok, 1);
    chk("t5 first after ptr++", off_addr[s], 12);
    chk("t5 wrapped", off_addr[s+1], 10);
    step();
    scan_en = 0;
    wait_idle(20, ok);
    step();

    // wrap from ptr 127 to 0
    do_reset();
    clr_mem();
    poke(10'd126, 16'h8000);
    scan_en = 1;
    wait_valid(400, n);
    chk("t6 addr126", upd_if.addr, 126);
    step();
    scan_en = 0; upd_if.ready = 1;
    step();
    upd_if.ready = 0;
    wait_idle(20, ok);
    chk("t6 idle", ok, 1);
    step();
    hd = 16'($urandom);
    host_op(1, 10'h3FF, hd, rd, ok);
    chk("t6 stat ack", ok, 1);
    pa = 15'($urandom); pb = 15'($urandom);
    poke(10'd127, {1'b1, pa});
    poke(10'd0, {1'b1, pb});
    s = off_addr.size();
    scan_en = 1; upd_if.ready = 1;
    wait_offers(s + 2, 100, ok);
    chk("t6 offers", ok, 1);
    chk("t6 off127", {off_addr[s], off_dat[s]}, {7'd127, pa});
    chk("t6 off0", {off_addr[s+1], off_dat[s+1]}, {7'd0, pb});
    step();
    scan_en = 0;
    wait_idle(20, ok);
`ifdef TOF_SCHED_STATS_EN
    chk("t6 count", upd_count, 2);
    chk("t6 3ff untouched", mem[10'h3FF], 16'h0000);
`else
    chk("t6 3ff plain", mem[10'h3FF], hd);
`endif
    step();

    // randomized soak: random flags, ready and monitor traffic
    do_reset();
    clr_mem();
    exp_a.delete(); exp_d.delete();
    for (int a = 0; a < 128; a++) begin
      hv = 16'($urandom);
      hv[15] = ($urandom_range(0, 3) == 0);
      cfg_exp[a] = {1'b0, hv[14:0]};
      mon_exp[a] = 16'h0000;
      if (hv[15]) begin
        exp_a.push_back(7'(a));
        exp_d.push_back(hv[14:0]);
      end
      poke(10'(a), hv);
    end
    nexp = exp_a.size();
    s = off_addr.size();
    scan_en = 1;
    n = 0;
    while (off_addr.size() < s + nexp && n < 6000) begin
      upd_if.ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        mon_wr = 1;
        mon_addr = 7'($urandom);
        mon_dat = 16'($urandom);
        mon_exp[mon_addr] = mon_dat;
      end else begin
        mon_wr = 0;
      end
      step();
      n++;
    end
    mon_wr = 0; upd_if.ready = 1; scan_en = 0;
    wait_idle(400, ok);
    chk("soak idle", ok, 1);
    chk("soak noff", off_addr.size() - s, nexp);
    for (int i = 0; i < nexp; i++)
      if (s + i < off_addr.size())
        chk($sformatf("soak off %0d", i),
            {off_addr[s+i], off_dat[s+i]}, {exp_a[i], exp_d[i]});
    bad = 0;
    for (int a = 0; a < 128; a++)
      if (mem[a] !== cfg_exp[a]) bad++;
    chk("soak cfg cleared", bad, 0);
    bad = 0;
    for (int a = 0; a < 128; a++)
      if (mem[10'h080 + a] !== mon_exp[a]) bad++;
    chk("soak mon", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
